// File: rtl/pulse_stretch_scheduler.sv
// ---------------------------------------------------------------------------
// pulse_stretch_scheduler
//
// Round-robin scheduler sharing one stretched-pulse output among NREQ
// requesters. Each trigger is latched as a pending request. Pending requests
// are granted in rotating order; every grant drives Q high for exactly DUR
// cycles, followed by GAP forced-low guard cycles.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   sres       synchronous active-high reset
//   Trigger    per-channel request, level sampled every clk
//   Q          shared stretched pulse
//   Owner      one-hot channel owning the current pulse, 0 when no pulse
//   Owner_idx  binary index of Owner, 0 when no pulse
//   Busy       high whenever the scheduler is not idle
//   Pending    latched, not-yet-granted requests
//   Overrun    sticky, set when a channel re-triggers while still pending
//
// State      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no pulse in progress, waiting for any Pending bit
// ST_PULSE   | Q high for DUR cycles on behalf of the granted channel
// ST_GAP     | Q forced low for GAP guard cycles before the next grant
// ---------------------------------------------------------------------------
module pulse_stretch_scheduler #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2,
    parameter int DUR   = 3,
    parameter int GAP   = 1,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             sres,
    input  logic [NREQ-1:0]  Trigger,
    output logic             Q,
    output logic [NREQ-1:0]  Owner,
    output logic [IDX_W-1:0] Owner_idx,
    output logic             Busy,
    output logic [NREQ-1:0]  Pending,
    output logic [NREQ-1:0]  Overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DUR_LAST = CNT_W'(DUR - 1);
    // With GAP=0 the GAP state is never entered; the value only has to fit.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit               NO_GAP   = (GAP == 0);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NREQ - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    int               cand_int;
    logic [IDX_W-1:0] cand;
    logic             grant;
    logic [NREQ-1:0]  grant_onehot;
    logic [NREQ-1:0]  grant_mask;

    // Rotating priority: scan from ptr+1 upward with wraparound, so the
    // channel granted last has the lowest priority on the next decision.
    // Only the registered Pending vector is considered.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_int  = 0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_int = (int'(ptr) + i) % NREQ;
            cand     = IDX_W'(cand_int);
            if (!arb_found && Pending[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // A grant is only taken at the points where a new pulse may begin.
    always_comb begin
        grant = 1'b0;
        case (state)
            ST_IDLE:  grant = arb_found;
            ST_PULSE: grant = arb_found && NO_GAP && (cnt == DUR_LAST);
            ST_GAP:   grant = arb_found && (cnt == GAP_LAST);
            default:  grant = 1'b0;
        endcase
    end

    always_comb begin
        grant_onehot          = '0;
        grant_onehot[arb_idx] = 1'b1;
        grant_mask            = grant ? grant_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (sres) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ptr       <= PTR_INIT;
            Q         <= 1'b0;
            Owner     <= '0;
            Owner_idx <= '0;
            Busy      <= 1'b0;
            Pending   <= '0;
            Overrun   <= '0;
        end else begin
            // A trigger on the grant edge of its own channel re-queues it:
            // the set term is applied after the grant clear.
            Pending <= (Pending & ~grant_mask) | Trigger;
            Overrun <= Overrun | (Trigger & Pending & ~grant_mask);

            if (grant) begin
                ptr <= arb_idx;
            end

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state     <= ST_PULSE;
                        cnt       <= '0;
                        Q         <= 1'b1;
                        Owner     <= grant_onehot;
                        Owner_idx <= arb_idx;
                        Busy      <= 1'b1;
                    end
                end

                ST_PULSE: begin
                    if (cnt == DUR_LAST) begin
                        cnt <= '0;
                        if (!NO_GAP) begin
                            state     <= ST_GAP;
                            Q         <= 1'b0;
                            Owner     <= '0;
                            Owner_idx <= '0;
                        end else if (grant) begin
                            // Back-to-back pulses: Q stays high, owner switches.
                            Owner     <= grant_onehot;
                            Owner_idx <= arb_idx;
                        end else begin
                            state     <= ST_IDLE;
                            Q         <= 1'b0;
                            Owner     <= '0;
                            Owner_idx <= '0;
                            Busy      <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (grant) begin
                            state     <= ST_PULSE;
                            Q         <= 1'b1;
                            Owner     <= grant_onehot;
                            Owner_idx <= arb_idx;
                        end else begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    Q         <= 1'b0;
                    Owner     <= '0;
                    Owner_idx <= '0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pulse_stretch_scheduler
//
// Two instances: dut_a with default parameters (DUR=3, GAP=1) and dut_b with
// DUR=1, GAP=0 for back-to-back pulses. Both share trig/sres. Each vector
// record gives the inputs for one cycle and the outputs expected during that
// same cycle; start=1 applies a reset first and restarts cycle numbering.
// ---------------------------------------------------------------------------
module tb_pulse_stretch_scheduler;

    logic       clk;
    logic       sres;
    logic [3:0] trig;

    logic       q_a, busy_a, q_b, busy_b;
    logic [3:0] owner_a, pend_a, ovr_a, owner_b, pend_b, ovr_b;
    logic [1:0] idx_a, idx_b;

    int checks = 0;
    int errors = 0;

    pulse_stretch_scheduler #(.NREQ(4), .IDX_W(2), .DUR(3), .GAP(1), .CNT_W(2)) dut_a (
        .clk(clk), .sres(sres), .Trigger(trig), .Q(q_a), .Owner(owner_a),
        .Owner_idx(idx_a), .Busy(busy_a), .Pending(pend_a), .Overrun(ovr_a)
    );

    pulse_stretch_scheduler #(.NREQ(4), .IDX_W(2), .DUR(1), .GAP(0), .CNT_W(1)) dut_b (
        .clk(clk), .sres(sres), .Trigger(trig), .Q(q_b), .Owner(owner_b),
        .Owner_idx(idx_b), .Busy(busy_b), .Pending(pend_b), .Overrun(ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int         test;
        bit         start;
        bit         sel;
        logic [3:0] trig;
        logic       rst;
        logic       q;
        logic [3:0] owner;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input int test, input bit start, input bit sel, input int n,
                     input logic [3:0] t, input logic r, input logic q,
                     input logic [3:0] own, input logic busy,
                     input logic [3:0] pend, input logic [3:0] ovr);
        vec_t rec;
        rec.test = test; rec.start = start; rec.sel = sel; rec.trig = t;
        rec.rst = r; rec.q = q; rec.owner = own; rec.busy = busy;
        rec.pend = pend; rec.ovr = ovr;
        for (int k = 0; k < n; k++) begin
            vecs.push_back(rec);
            rec.start = 1'b0;
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
        return r;
    endfunction

    task automatic chk(input string name, input int test, input int cyc,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (test %0d cycle %0d): got %b, expected %b",
                     name, test, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sres = 1'b1;
        trig = 4'b0000;
        step();
        step();
        sres = 1'b0;
    endtask

    initial begin
        vec_t r;
        int   cyc;
        int   k;
        int   len;

        sres = 1'b1;
        trig = 4'b0000;

        //    test st sel n  trig     rst q  owner    busy pend     ovr
        // 1: single request on channel 2
        v(1, 1, 0, 1, 4'b0100, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(1, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0100, 4'b0000);
        v(1, 0, 0, 3, 4'b0000, 0, 1, 4'b0100, 1, 4'b0000, 4'b0000);
        v(1, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
        v(1, 0, 0, 2, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        // 2: all four at once, served 0,1,2,3
        v(2, 1, 0, 1, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(2, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000);
        v(2, 0, 0, 3, 4'b0000, 0, 1, 4'b0001, 1, 4'b1110, 4'b0000);
        v(2, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b1110, 4'b0000);
        v(2, 0, 0, 3, 4'b0000, 0, 1, 4'b0010, 1, 4'b1100, 4'b0000);
        v(2, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b1100, 4'b0000);
        v(2, 0, 0, 3, 4'b0000, 0, 1, 4'b0100, 1, 4'b1000, 4'b0000);
        v(2, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b1000, 4'b0000);
        v(2, 0, 0, 3, 4'b0000, 0, 1, 4'b1000, 1, 4'b0000, 4'b0000);
        v(2, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
        v(2, 0, 0, 2, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        // 3: fairness, pointer left at 1 so channel 0 goes first
        v(3, 1, 0, 1, 4'b0010, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(3, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0010, 4'b0000);
        v(3, 0, 0, 3, 4'b0000, 0, 1, 4'b0010, 1, 4'b0000, 4'b0000);
        v(3, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
        v(3, 0, 0, 1, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(3, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0011, 4'b0000);
        v(3, 0, 0, 3, 4'b0000, 0, 1, 4'b0001, 1, 4'b0010, 4'b0000);
        v(3, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0010, 4'b0000);
        v(3, 0, 0, 3, 4'b0000, 0, 1, 4'b0010, 1, 4'b0000, 4'b0000);
        v(3, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
        v(3, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        // 4: channel 1 re-triggers while pending -> overrun, single pulse
        v(4, 1, 0, 1, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(4, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0011, 4'b0000);
        v(4, 0, 0, 1, 4'b0000, 0, 1, 4'b0001, 1, 4'b0010, 4'b0000);
        v(4, 0, 0, 1, 4'b0010, 0, 1, 4'b0001, 1, 4'b0010, 4'b0000);
        v(4, 0, 0, 1, 4'b0000, 0, 1, 4'b0001, 1, 4'b0010, 4'b0010);
        v(4, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0010, 4'b0010);
        v(4, 0, 0, 3, 4'b0000, 0, 1, 4'b0010, 1, 4'b0000, 4'b0010);
        v(4, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0010);
        v(4, 0, 0, 2, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0010);
        // 5: channel 0 re-triggers after its grant -> second ch0 pulse
        v(5, 1, 0, 1, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(5, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0011, 4'b0000);
        v(5, 0, 0, 1, 4'b0000, 0, 1, 4'b0001, 1, 4'b0010, 4'b0000);
        v(5, 0, 0, 1, 4'b0001, 0, 1, 4'b0001, 1, 4'b0010, 4'b0000);
        v(5, 0, 0, 1, 4'b0000, 0, 1, 4'b0001, 1, 4'b0011, 4'b0000);
        v(5, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0011, 4'b0000);
        v(5, 0, 0, 3, 4'b0000, 0, 1, 4'b0010, 1, 4'b0001, 4'b0000);
        v(5, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000);
        v(5, 0, 0, 3, 4'b0000, 0, 1, 4'b0001, 1, 4'b0000, 4'b0000);
        v(5, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
        v(5, 0, 0, 2, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        // 6: reset mid-pulse, then a fresh request on channel 3
        v(6, 1, 0, 1, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 0, 1, 4'b0001, 1, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 1, 1, 4'b0001, 1, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b1000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b1000, 4'b0000);
        v(6, 0, 0, 3, 4'b0000, 0, 1, 4'b1000, 1, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000);
        v(6, 0, 0, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        // 7: DUR=1 GAP=0, back-to-back pulses with owner switch
        v(7, 1, 1, 1, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        v(7, 0, 1, 1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0011, 4'b0000);
        v(7, 0, 1, 1, 4'b0000, 0, 1, 4'b0001, 1, 4'b0010, 4'b0000);
        v(7, 0, 1, 1, 4'b0000, 0, 1, 4'b0010, 1, 4'b0000, 4'b0000);
        v(7, 0, 1, 2, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000);

        cyc = 0;
        for (int n = 0; n < vecs.size(); n++) begin
            r = vecs[n];
            if (r.start) begin
                do_reset();
                cyc = 0;
            end
            trig = r.trig;
            sres = r.rst;
            chk("q",         r.test, cyc, {3'b0, r.sel ? q_b : q_a}, {3'b0, r.q});
            chk("owner",     r.test, cyc, r.sel ? owner_b : owner_a, r.owner);
            chk("owner_idx", r.test, cyc, {2'b0, r.sel ? idx_b : idx_a}, {2'b0, idx_of(r.owner)});
            chk("busy",      r.test, cyc, {3'b0, r.sel ? busy_b : busy_a}, {3'b0, r.busy});
            chk("pending",   r.test, cyc, r.sel ? pend_b : pend_a, r.pend);
            chk("overrun",   r.test, cyc, r.sel ? ovr_b : ovr_a, r.ovr);
            step();
            cyc++;
        end
        sres = 1'b0;
        trig = 4'b0000;

        // Hand sequence: latency and pulse length on dut_a, channel 1.
        do_reset();
        trig = 4'b0010;
        step();
        trig = 4'b0000;
        for (k = 0; k < 20; k++) begin
            if (q_a) break;
            step();
        end
        chk("latency_a", 8, k, 4'(k), 4'd1);
        chk("idx_a", 8, k, {2'b0, idx_a}, 4'd1);
        len = 0;
        while (q_a && len < 10) begin
            len++;
            step();
        end
        chk("pulse_len_a", 8, len, 4'(len), 4'd3);
        chk("gap_q_a", 8, len, {3'b0, q_a}, 4'd0);
        chk("gap_busy_a", 8, len, {3'b0, busy_a}, 4'd1);

        // Hand sequence: four back-to-back single-cycle pulses on dut_b.
        do_reset();
        trig = 4'b1111;
        step();
        trig = 4'b0000;
        for (k = 0; k < 20; k++) begin
            if (q_b) break;
            step();
        end
        chk("latency_b", 9, k, 4'(k), 4'd1);
        for (int j = 0; j < 4; j++) begin
            chk("chain_q_b", 9, j, {3'b0, q_b}, 4'd1);
            chk("chain_owner_b", 9, j, owner_b, 4'(1 << j));
            step();
        end
        chk("end_q_b", 9, 4, {3'b0, q_b}, 4'd0);
        chk("end_busy_b", 9, 4, {3'b0, busy_b}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_scheduler.md
Name: pulse_stretch_scheduler

Overview:
Round-robin scheduler that shares one stretched-pulse output among NREQ requesters.
- Each trigger is latched as a pending request.
- Pending requests are granted in rotating order; each grant drives Q high for exactly DUR cycles, followed by GAP guard cycles.
- Sits between per-channel event sources and a single shared actuator or strobe line, and reports which channel owns the pulse.

Parameters:
NREQ, 4, number of requesters (>=2)
IDX_W, 2, least m with 2^m >= NREQ
DUR, 3, stretched pulse length in clk cycles (>=1)
GAP, 1, forced-low guard cycles after each pulse (>=0)
CNT_W, 2, least m with 2^m > max(DUR-1, GAP-1, 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
sres  input  1  synchronous active-high reset
Trigger  input  NREQ  per-channel request; level sampled every clk, nominally one-cycle pulses
Q  output  1  shared stretched pulse
Owner  output  NREQ  one-hot channel owning the current pulse; 0 when no pulse
Owner_idx  output  IDX_W  binary index of Owner; 0 when no pulse
Busy  output  1  high whenever state != IDLE
Pending  output  NREQ  latched, not-yet-granted requests
Overrun  output  NREQ  sticky; Trigger[i] seen while Pending[i] already 1

Behaviour:
- Reset: sres high at an edge forces the following outputs and registers to zero on the next cycle:
  - Outputs: Q, Owner, Owner_idx, Busy, Pending, Overrun.
  - Internal: state=IDLE, counter=0, RR pointer=NREQ-1 (channel 0 is highest priority first).
  - sres overrides everything, including mid-pulse; in-flight and pending requests are dropped.
- Request latch:
  - Trigger[i]=1 at an edge sets Pending[i].
  - Pending[i] clears at the edge that grants channel i.
  - Trigger[i] on the same edge as its grant: set wins, Pending[i] stays 1 (re-queued).
- Overrun[i]:
  - Sets when Trigger[i]=1 and Pending[i]=1 at the same edge, and no grant to i occurs on that edge.
  - Cleared only by sres.
  - The duplicate request is merged; no extra pulse.
- Arbitration:
  - Scan from pointer+1 mod NREQ upward with wraparound; the first Pending bit wins.
  - The pointer updates to the granted index at the grant edge.
  - Arbitration sees registered Pending only, never raw Trigger.
- States:
  - IDLE:
    - Q=0, Busy=0.
    - Any Pending -> grant, go PULSE, counter=0.
  - PULSE:
    - Q=1; Owner/Owner_idx hold the granted channel.
    - Counter increments each cycle.
    - At counter=DUR-1: if GAP>0 go to GAP with counter=0.
    - If GAP=0: when any Pending, re-grant and stay in PULSE (Q remains high, Owner switches that edge); otherwise go IDLE.
  - GAP:
    - Q=0, Owner=0, Busy=1.
    - At counter=GAP-1: any Pending -> grant, go PULSE; else go IDLE.
- Latency: Trigger high in cycle t -> Pending in t+1 -> Q high cycles t+2..t+1+DUR when the scheduler is idle.
- Q pulse length is exactly DUR cycles per grant, never truncated except by sres.
- Counter width CNT_W; it never exceeds max(DUR,GAP)-1, so no wraparound is possible.

Test Plan:
1. Defaults; Trigger=4'b0100 in cycle 0 only:
   - Pending=4'b0100 in cycle 1.
   - Q=1, Owner=4'b0100, Owner_idx=2 in cycles 2-4.
   - Q=0, Busy=1 in cycle 5.
   - Busy=0 from cycle 6.
2. Defaults; Trigger=4'b1111 in cycle 0:
   - Grants in order 0,1,2,3.
   - Q high in cycles 2-4, 6-8, 10-12, 14-16; low in 5, 9, 13, 17.
   - Busy=0 from cycle 18; Overrun stays 0.
3. Fairness, defaults:
   - Serve channel 1 alone (Trigger[1] in cycle 0).
   - Then Trigger=4'b0011 in cycle 6; grant order is 0 then 1 (pointer at 1).
   - Q high in cycles 8-10 with Owner=0001, then 12-14 with Owner=0010.
4. Overrun, defaults; Trigger=4'b0011 in cycle 0, Trigger=4'b0010 in cycle 3:
   - Overrun=4'b0010 from cycle 4.
   - Exactly one pulse for channel 1 (cycles 6-8).
   - Trigger[0] repeated in cycle 3 instead -> re-queued, no overrun, second ch0 pulse at cycles 10-12.
5. Defaults; Trigger=4'b0001 in cycle 0, sres=1 in cycle 3:
   - In cycle 4, Q, Owner, Busy, Pending and Overrun are all 0.
   - Trigger=4'b1000 in cycle 5 -> Q high in cycles 7-9.
6. DUR=1, GAP=0; Trigger=4'b0011 in cycle 0:
   - Q continuously high in cycles 2-3.
   - Owner=0001 in cycle 2, Owner=0010 in cycle 3.
   - Q=0, Busy=0 in cycle 4.
